// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: AXI4-Lite response codes and default widths shared by slave and master sides.
package axi_lite_pkg;
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_RESPONSE_WIDTH = 2;
    localparam int DEFAULT_NUM_REGS       = 16;
endpackage

// File: rtl/axi_lite_slave_rd.sv
// axi_lite_slave_rd: AXI4-Lite read channel; decodes araddr and registers one response until rready.
module axi_lite_slave_rd
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int RESPONSE_WIDTH = DEFAULT_RESPONSE_WIDTH,
    parameter int NUM_REGS       = DEFAULT_NUM_REGS
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           arvalid,
    input  logic [DATA_WIDTH-1:0]          araddr,
    output logic                           arready,
    output logic                           rvalid,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [RESPONSE_WIDTH-1:0]      rresp,
    input  logic                           rready,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_i
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [DATA_WIDTH-1:0] ADDR_END = DATA_WIDTH'(NUM_REGS * 4);
    localparam logic [RESPONSE_WIDTH-1:0] OKAY   = RESPONSE_WIDTH'(RESP_OKAY);
    localparam logic [RESPONSE_WIDTH-1:0] SLVERR = RESPONSE_WIDTH'(RESP_SLVERR);

    logic                      rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic [RESPONSE_WIDTH-1:0] rresp_q, rresp_d;
    logic                      ar_hs, ar_ok;
    logic [IDX_W-1:0]          ar_idx;

    // Ready is gated by resetn so it drops the instant reset asserts.
    assign arready = resetn && !rvalid_q;
    assign ar_hs   = arvalid && arready;
    assign ar_ok   = (araddr < ADDR_END) && (araddr[1:0] == 2'b00);
    assign ar_idx  = araddr[2 +: IDX_W];
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

    always_comb begin
        rvalid_d = ar_hs || (rvalid_q && !rready);
        rdata_d  = ar_hs ? (ar_ok ? regs_i[ar_idx*DATA_WIDTH +: DATA_WIDTH] : '0) : rdata_q;
        rresp_d  = ar_hs ? (ar_ok ? OKAY : SLVERR) : rresp_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end
endmodule

// File: rtl/axi_lite_slave_regfile.sv
// axi_lite_slave_regfile: AXI4-Lite slave register file; write path and registers here, reads in axi_lite_slave_rd.
module axi_lite_slave_regfile
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int RESPONSE_WIDTH = DEFAULT_RESPONSE_WIDTH,
    parameter int NUM_REGS       = DEFAULT_NUM_REGS
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           awvalid,
    input  logic [DATA_WIDTH-1:0]          awaddr,
    input  logic [2:0]                     awprot,
    output logic                           awready,
    input  logic                           wvalid,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    output logic                           wready,
    output logic                           bvalid,
    output logic [RESPONSE_WIDTH-1:0]      bresp,
    input  logic                           bready,
    input  logic                           arvalid,
    input  logic [DATA_WIDTH-1:0]          araddr,
    input  logic [2:0]                     arprot,
    output logic                           arready,
    output logic                           rvalid,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [RESPONSE_WIDTH-1:0]      rresp,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam logic [DATA_WIDTH-1:0] ADDR_END = DATA_WIDTH'(NUM_REGS * 4);
    localparam logic [RESPONSE_WIDTH-1:0] OKAY   = RESPONSE_WIDTH'(RESP_OKAY);
    localparam logic [RESPONSE_WIDTH-1:0] SLVERR = RESPONSE_WIDTH'(RESP_SLVERR);

    logic                           aw_full_q, aw_full_d;
    logic [DATA_WIDTH-1:0]          aw_addr_q, aw_addr_d;
    logic                           w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0]          w_data_q, w_data_d;
    logic [STRB_W-1:0]              w_strb_q, w_strb_d;
    logic                           bvalid_q, bvalid_d;
    logic [RESPONSE_WIDTH-1:0]      bresp_q, bresp_d;
    logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;
    logic                           aw_hs, w_hs, commit, aw_ok;
    logic [IDX_W-1:0]               aw_idx;
    logic                           unused_prot;

    assign unused_prot = ^{awprot, arprot};

    // Readies are gated by resetn so they drop the instant reset asserts.
    assign awready = resetn && !aw_full_q && !bvalid_q;
    assign wready  = resetn && !w_full_q && !bvalid_q;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign commit  = aw_full_q && w_full_q;
    assign aw_ok   = (aw_addr_q < ADDR_END) && (aw_addr_q[1:0] == 2'b00);
    assign aw_idx  = aw_addr_q[2 +: IDX_W];
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign regs_o  = regs_q;

    always_comb begin
        aw_full_d = commit ? 1'b0 : (aw_full_q || aw_hs);
        aw_addr_d = aw_hs ? awaddr : aw_addr_q;
        w_full_d  = commit ? 1'b0 : (w_full_q || w_hs);
        w_data_d  = w_hs ? wdata : w_data_q;
        w_strb_d  = w_hs ? wstrb : w_strb_q;
        bvalid_d  = commit || (bvalid_q && !bready);
        bresp_d   = commit ? (aw_ok ? OKAY : SLVERR) : bresp_q;
        regs_d    = regs_q;
        for (int k = 0; k < STRB_W; k++)
            if (commit && aw_ok && w_strb_q[k])
                regs_d[aw_idx*DATA_WIDTH + k*8 +: 8] = w_data_q[k*8 +: 8];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            regs_q    <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            regs_q    <= regs_d;
        end
    end

    axi_lite_slave_rd #(
        .DATA_WIDTH    (DATA_WIDTH),
        .RESPONSE_WIDTH(RESPONSE_WIDTH),
        .NUM_REGS      (NUM_REGS)
    ) u_rd (
        .clk    (clk),
        .resetn (resetn),
        .arvalid(arvalid),
        .araddr (araddr),
        .arready(arready),
        .rvalid (rvalid),
        .rdata  (rdata),
        .rresp  (rresp),
        .rready (rready),
        .regs_i (regs_q)
    );
endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// tb_axi_lite_slave_regfile: directed AXI4-Lite transactions against a per-register expected model.
module tb_axi_lite_slave_regfile;
    localparam int DW = 32;
    localparam int RW = 2;
    localparam int NR = 16;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [DW-1:0]   awaddr = '0, wdata = '0, araddr = '0;
    logic [2:0]      awprot = 3'd0, arprot = 3'd0;
    logic [DW/8-1:0] wstrb = '0;
    logic            awready, wready, bvalid, arready, rvalid;
    logic [RW-1:0]   bresp, rresp;
    logic [DW-1:0]   rdata;
    logic [NR*DW-1:0] regs_o;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] model [NR];
    logic [1:0]    resp;
    logic [DW-1:0] data;
    int            lat;

    axi_lite_slave_regfile dut (
        .clk(clk), .resetn(resetn),
        .awvalid(awvalid), .awaddr(awaddr), .awprot(awprot), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bready(bready),
        .arvalid(arvalid), .araddr(araddr), .arprot(arprot), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
        .regs_o(regs_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < NR; i++)
            chk($sformatf("%s_r%0d", tag, i), regs_o[i*DW +: DW], model[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [DW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                             output logic [1:0] r, output int l);
        bit aw_done = 0, w_done = 0, a_rdy, w_rdy;
        int n = 0;
        awvalid = 1; awaddr = a; wvalid = 1; wdata = d; wstrb = s;
        while (!(aw_done && w_done) && n < 20) begin
            a_rdy = awready; w_rdy = wready;
            tick(); n++;
            if (a_rdy) begin aw_done = 1; awvalid = 0; end
            if (w_rdy) begin w_done = 1; wvalid = 0; end
        end
        awvalid = 0; wvalid = 0;
        chk("wr_handshake", {62'd0, aw_done, w_done}, 64'd3);
        l = 0;
        while (!bvalid && l < 20) begin tick(); l++; end
        chk("wr_bvalid", bvalid, 1);
        r = bresp;
        bready = 1; tick(); bready = 0;
        // Mirror the write into the model only when the address decodes.
        if (a < NR*4 && a[1:0] == 2'b00)
            for (int k = 0; k < 4; k++)
                if (s[k]) model[a[5:2]][k*8 +: 8] = d[k*8 +: 8];
    endtask

    task automatic axi_read(input logic [DW-1:0] a, output logic [DW-1:0] d, output logic [1:0] r);
        bit done = 0, rdy;
        int n = 0;
        arvalid = 1; araddr = a;
        while (!done && n < 20) begin
            rdy = arready;
            tick(); n++;
            if (rdy) done = 1;
        end
        arvalid = 0;
        chk("rd_handshake", done, 1);
        while (!rvalid && n < 40) begin tick(); n++; end
        chk("rd_rvalid", rvalid, 1);
        d = rdata; r = rresp;
        rready = 1; tick(); rready = 0;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) model[i] = '0;
        #2;
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk_regs("rst");
        #20 resetn = 1;
        #1;
        chk("post_rst_awready", awready, 1);
        chk("post_rst_wready", wready, 1);
        chk("post_rst_arready", arready, 1);
        tick();

        axi_write(32'h04, 32'hDEADBEEF, 4'hF, resp, lat);
        chk("w1_latency", lat, 1);
        chk("w1_bresp", resp, 2'b00);
        chk("w1_reg1", regs_o[1*DW +: DW], 32'hDEADBEEF);
        axi_read(32'h04, data, resp);
        chk("r1_rdata", data, 32'hDEADBEEF);
        chk("r1_rresp", resp, 2'b00);

        axi_write(32'h08, 32'hFFFFFFFF, 4'hF, resp, lat);
        wvalid = 1; wdata = 32'h12345678; wstrb = 4'h5;
        tick();
        wvalid = 0;
        chk("w2_wready_held", wready, 0);
        tick();
        chk("w2_wready_held2", wready, 0);
        chk("w2_no_early_b", bvalid, 0);
        awvalid = 1; awaddr = 32'h08;
        tick();
        awvalid = 0;
        chk("w2_awready_after", awready, 0);
        tick();
        chk("w2_bvalid", bvalid, 1);
        chk("w2_bresp", bresp, 2'b00);
        chk("w2_wready_during_b", wready, 0);
        chk("w2_reg2", regs_o[2*DW +: DW], 32'hFF34FF78);
        bready = 1; tick(); bready = 0;
        model[2] = 32'hFF34FF78;
        chk("w2_wready_free", wready, 1);

        axi_write(32'h40, 32'hCAFEF00D, 4'hF, resp, lat);
        chk("w3_bresp_range", resp, 2'b10);
        axi_write(32'h06, 32'hCAFEF00D, 4'hF, resp, lat);
        chk("w3_bresp_align", resp, 2'b10);
        chk_regs("w3");
        axi_read(32'h40, data, resp);
        chk("r3_rdata", data, 32'h0);
        chk("r3_rresp", resp, 2'b10);

        axi_write(32'h04, 32'h00000000, 4'h0, resp, lat);
        chk("w4_strb0_bresp", resp, 2'b00);
        chk("w4_strb0_reg1", regs_o[1*DW +: DW], 32'hDEADBEEF);

        awvalid = 1; awaddr = 32'h10; wvalid = 1; wdata = 32'h0BADF00D; wstrb = 4'hF;
        tick();
        awvalid = 0; wvalid = 0;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("hold_bvalid", bvalid, 1);
            chk("hold_bresp", bresp, 2'b00);
            chk("hold_awready", awready, 0);
            chk("hold_wready", wready, 0);
            tick();
        end
        bready = 1; tick(); bready = 0;
        model[4] = 32'h0BADF00D;
        chk("hold_bvalid_clr", bvalid, 0);
        arvalid = 1; araddr = 32'h10;
        tick();
        arvalid = 0;
        for (int c = 0; c < 5; c++) begin
            chk("hold_rvalid", rvalid, 1);
            chk("hold_rdata", rdata, 32'h0BADF00D);
            chk("hold_rresp", rresp, 2'b00);
            chk("hold_arready", arready, 0);
            tick();
        end
        rready = 1; tick(); rready = 0;
        chk("hold_rvalid_clr", rvalid, 0);
        chk("hold_arready_free", arready, 1);

        axi_write(32'h0C, 32'h11111111, 4'hF, resp, lat);
        awvalid = 1; awaddr = 32'h0C; wvalid = 1; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
        tick();
        awvalid = 0; wvalid = 0;
        arvalid = 1; araddr = 32'h0C;
        tick();
        arvalid = 0;
        chk("same_edge_bvalid", bvalid, 1);
        chk("same_edge_rvalid", rvalid, 1);
        chk("same_edge_rdata", rdata, 32'h11111111);
        chk("same_edge_reg3", regs_o[3*DW +: DW], 32'hA5A5A5A5);
        bready = 1; rready = 1; tick(); bready = 0; rready = 0;
        model[3] = 32'hA5A5A5A5;
        axi_read(32'h0C, data, resp);
        chk("same_edge_reread", data, 32'hA5A5A5A5);
        chk_regs("pre_rst");

        arvalid = 1; araddr = 32'h0C;
        tick();
        arvalid = 0;
        awvalid = 1; awaddr = 32'h14;
        tick();
        awvalid = 0;
        #2 resetn = 0;
        #1;
        chk("mid_rst_awready", awready, 0);
        chk("mid_rst_wready", wready, 0);
        chk("mid_rst_arready", arready, 0);
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_rdata", rdata, 32'h0);
        chk("mid_rst_rresp", rresp, 2'b00);
        for (int i = 0; i < NR; i++) model[i] = '0;
        chk_regs("mid_rst");
        #1 resetn = 1;
        tick();
        wvalid = 1; wdata = 32'h55AA55AA; wstrb = 4'hF;
        tick();
        wvalid = 0;
        for (int c = 0; c < 5; c++) begin
            chk("orphan_w_bvalid", bvalid, 0);
            chk("orphan_w_reg5", regs_o[5*DW +: DW], 32'h0);
            tick();
        end
        chk_regs("final");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/axi_lite_slave_regfile.md
AXI_LITE_SLAVE_REGFILE -- requirements
Module: axi_lite_slave_regfile

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data and address width.
REQ-002 SHALL have parameter RESPONSE_WIDTH, default 2, bresp/rresp width.
REQ-003 SHALL have parameter NUM_REGS, default 16, number of word registers (power of 2, 2..256).
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 awvalid/awaddr/awprot  in  1/DATA_WIDTH/3  write address; awprot ignored.
REQ-007 awready  out  1  write address accept.
REQ-008 wvalid/wdata/wstrb  in  1/DATA_WIDTH/DATA_WIDTH/8  write data, byte strobes.
REQ-009 wready  out  1  write data accept.
REQ-010 bvalid/bresp  out  1/RESPONSE_WIDTH  write response; bready  in  1.
REQ-011 arvalid/araddr/arprot  in  1/DATA_WIDTH/3  read address; arprot ignored; arready  out  1.
REQ-012 rvalid/rdata/rresp  out  1/DATA_WIDTH/RESPONSE_WIDTH  read response; rready  in  1.
REQ-013 regs_o  out  NUM_REGS*DATA_WIDTH  flat register contents, reg i at bits [i*DATA_WIDTH +: DATA_WIDTH], to user logic.

Function
REQ-014 SHALL act as AXI4-Lite slave; write and read channels independent and concurrently active.
REQ-015 Decode: index = addr[2 +: log2(NUM_REGS)]; valid iff addr < NUM_REGS*4 and addr[1:0]==0; else error.
REQ-016 AW and W SHALL be accepted independently, in any order or same cycle, each into a one-deep holding register with a full flag.
REQ-017 awready = !aw_full && !bvalid; wready = !w_full && !bvalid.
REQ-018 Cycle after both holds full (or N+1 when both handshake at N): valid addr -> bytes with wstrb[k]=1 updated, others kept; bvalid=1, bresp=OKAY (2'b00), holds cleared same edge.
REQ-019 Invalid write address: no register changes; bvalid=1, bresp=SLVERR (2'b10).
REQ-020 bvalid/bresp SHALL stay stable until bready; bvalid clears on the bvalid&&bready edge; next AW/W accepted from the following cycle.
REQ-021 wstrb=0 with valid address: no change, bresp=OKAY.
REQ-022 arready = !rvalid; on arvalid&&arready at N, rdata/rresp registered, rvalid=1 at N+1.
REQ-023 Valid read: rdata = register value at edge N, rresp=OKAY; invalid: rdata=0, rresp=SLVERR.
REQ-024 Same-edge write commit and AR handshake on same register: read returns pre-write value.
REQ-025 rvalid/rdata/rresp SHALL stay stable until rready; rvalid clears on rvalid&&rready edge.
REQ-026 Master deasserting valid before handshake SHALL not corrupt state; only completed handshakes are captured.
REQ-027 regs_o SHALL reflect writes the cycle after commit.

Reset
REQ-028 resetn low SHALL immediately force awready, wready, bvalid, arready, rvalid to 0, bresp/rresp/rdata to 0, all registers and regs_o to 0, hold flags cleared.
REQ-029 Reset mid-transaction SHALL discard held AW/W and pending responses; no partial write.
REQ-030 First cycle after resetn rises: awready=wready=arready=1.

Structure
REQ-031 Package axi_lite_pkg SHALL hold RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11 and default width constants, shared with the master.
REQ-032 One sub-module is natural: axi_lite_slave_rd (read channel: arready, decode, rdata/rresp, rvalid hold); write path and register array stay in the top.

Verification
REQ-033 Reset, single write 0x04 data 0xDEADBEEF wstrb 0xF, AW and W same cycle -> bvalid next cycle, bresp=00, regs_o reg1=0xDEADBEEF; read 0x04 -> rdata 0xDEADBEEF, rresp 00.
REQ-034 W two cycles before AW (0x08, 0x12345678, wstrb 0x5) over reg2=0xFFFFFFFF -> reg2=0xFF34FF78; wready low after W until bready handshake.
REQ-035 Write 0x40 and 0x06 (NUM_REGS=16) -> bresp=10 each, regs unchanged; read 0x40 -> rdata 0, rresp 10.
REQ-036 bready and rready held low 5 cycles -> bvalid/rvalid, bresp/rresp/rdata stable; awready, wready, arready low throughout.
REQ-037 Write commit to 0x0C (0xA5A5A5A5) on same edge as AR to 0x0C with old value 0x11111111 -> rdata 0x11111111; next read 0xA5A5A5A5.
REQ-038 resetn pulsed low after AW accepted, before W -> outputs zero immediately; subsequent W alone does not write; bvalid stays 0.
